btn_mode_ctrl: RTL and testbench
================================

# btn_mode_ctrl

Command controller that sits directly behind the four-button debounce stage. It turns the one-cycle debounced pulses and a mode switch into control for the stopwatch datapath (run/stop, clear) and the watch time-set datapath (edit enable, field select, increment/decrement). Button sequencing, priorities and the edit-timeout live only in this block; the datapaths act on its outputs.

## Interface
- EDIT_TIMEOUT, 500_000_000: idle cycles in edit before automatic exit (5 s at 100 MHz); minimum 2.
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- i_mode  in  1  0 = stopwatch, 1 = watch; level, already synchronous
- i_btn_run_stop  in  1  debounced one-cycle pulse (right button)
- i_btn_clear  in  1  debounced one-cycle pulse (left button)
- i_btn_u  in  1  debounced one-cycle pulse (up button)
- i_btn_d  in  1  debounced one-cycle pulse (down button)
- o_sw_run  out  1  level; stopwatch counting enable
- o_sw_clear  out  1  one-cycle pulse; stopwatch clear
- o_w_edit  out  1  level; watch in time-set mode
- o_w_field  out  2  edit field: 0 = sec, 1 = min, 2 = hour; 3 never driven
- o_w_inc  out  1  one-cycle pulse; increment selected field
- o_w_dec  out  1  one-cycle pulse; decrement selected field

## Operation
- FSM states: SW_STOP, SW_RUN, SW_CLEAR, W_VIEW, W_EDIT.
- Mode has top priority, checked every cycle:
  - i_mode=1 in any SW_* state -> W_VIEW.
  - i_mode=0 in any W_* state -> SW_STOP.
  - Button pulses in a mode-change cycle are dropped.
  - Edit is abandoned without an inc/dec.
- SW_STOP:
  - clear -> SW_CLEAR; run_stop -> SW_RUN.
  - Both in the same cycle: clear wins.
  - u/d ignored.
- SW_RUN: run_stop -> SW_STOP. Clear, u and d ignored; clear is not queued.
- SW_CLEAR: lasts exactly one cycle, then -> SW_STOP unconditionally. Pulses during it are dropped.
- W_VIEW: clear -> W_EDIT with field = 0. Run_stop, u and d ignored.
- W_EDIT: one action per cycle, priority clear > run_stop > u/d.
  - clear -> W_VIEW.
  - run_stop -> field advances 0->1->2->0.
  - u alone -> inc pulse.
  - d alone -> dec pulse.
  - u and d together -> no action, but the timeout still reloads.
- Edit timeout:
  - Idle counter is $clog2(EDIT_TIMEOUT) bits, cleared on W_EDIT entry and on any of the four pulses while in W_EDIT.
  - Otherwise it increments by 1 per cycle.
  - At count == EDIT_TIMEOUT-1 with no pulse that cycle -> W_VIEW.
  - The counter never wraps.
- Output decode:
  - o_sw_run = (state==SW_RUN).
  - o_sw_clear = (state==SW_CLEAR).
  - o_w_edit = (state==W_EDIT).
  - o_w_field = field register while in W_EDIT, otherwise 0.
  - o_w_inc/o_w_dec are registered pulses.
- No combinational path from any input to any output.

## Timing
- Reset asserted (low), asynchronously:
  - state = SW_STOP, field = 0, counter = 0.
  - All outputs are 0, regardless of i_mode.
- First edge after reset deasserts: if i_mode=1, state -> W_VIEW.
- Reset mid-edit or mid-run: immediately all outputs 0; no clear or inc pulse is emitted.
- Button pulse at edge N: the resulting state/output change is visible after edge N+1 (latency 1).
- o_sw_clear, o_w_inc and o_w_dec are exactly 1 cycle wide.
- Back-to-back u pulses on consecutive cycles give consecutive inc pulses; no pulse is lost or merged.
- Field advance is visible one cycle after the run_stop pulse.
- An inc/dec issued in the same cycle as a field change cannot occur, by the priority rule.
- Timeout exit: o_w_edit falls exactly EDIT_TIMEOUT cycles after the last pulse edge, or after entry if no pulse arrived.

## Test plan
Bench uses EDIT_TIMEOUT=16.

- Reset and mode: hold reset low with i_mode=1 -> all outputs 0. Release -> o_w_edit=0 and state W_VIEW after 1 edge; no spurious pulses.
- Stopwatch run/stop:
  - i_mode=0, run_stop pulse -> o_sw_run=1 one cycle later.
  - Second pulse -> o_sw_run=0.
  - Clear while running -> no o_sw_clear.
  - Clear while stopped -> exactly one o_sw_clear cycle, then o_sw_run stays 0.
- Simultaneous pulses:
  - In SW_STOP, clear+run_stop same cycle -> o_sw_clear pulse, o_sw_run stays 0.
  - In W_EDIT, u+d same cycle -> neither o_w_inc nor o_w_dec.
- Edit sequence:
  - i_mode=1, clear -> o_w_edit=1, field 0.
  - Three u pulses -> three o_w_inc pulses.
  - Run_stop ×3 -> field 1, 2, 0.
  - d -> one o_w_dec.
  - Clear -> o_w_edit=0.
- Edit timeout:
  - Enter edit, stay idle -> o_w_edit drops exactly 16 cycles after entry.
  - Repeat with a u pulse at cycle 10 -> drop at cycle 26.
- Mode change mid-edit: in W_EDIT with field=2, set i_mode=0 with a u pulse in the same cycle -> o_w_edit=0, o_w_field=0, no o_w_inc, o_sw_run=0.

Source files
------------

// File: rtl/btn_mode_ctrl.sv
// Button command controller: maps debounced button pulses and the mode switch
// onto stopwatch run/clear and watch time-set controls, including the edit timeout.
module btn_mode_ctrl #(
  parameter int unsigned EDIT_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mode,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_w_edit,
  output logic [1:0] o_w_field,
  output logic       o_w_inc,
  output logic       o_w_dec
);

  localparam int unsigned CNT_W = $clog2(EDIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EDIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    SW_STOP  = 3'd0,
    SW_RUN   = 3'd1,
    SW_CLEAR = 3'd2,
    W_VIEW   = 3'd3,
    W_EDIT   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       field, field_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             inc_q, inc_nxt;
  logic             dec_q, dec_nxt;
  logic             any_btn;

  // State, field, idle counter and action pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SW_STOP;
      field <= 2'd0;
      cnt   <= '0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nxt;
      field <= field_nxt;
      cnt   <= cnt_nxt;
      inc_q <= inc_nxt;
      dec_q <= dec_nxt;
    end
  end

  // Next-state logic; mode switch overrides any button activity
  always_comb begin
    state_nxt = state;
    field_nxt = field;
    cnt_nxt   = '0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    any_btn   = i_btn_run_stop | i_btn_clear | i_btn_u | i_btn_d;

    case (state)
      SW_STOP: begin
        if (i_mode)              state_nxt = W_VIEW;
        else if (i_btn_clear)    state_nxt = SW_CLEAR;
        else if (i_btn_run_stop) state_nxt = SW_RUN;
      end
      SW_RUN: begin
        if (i_mode)              state_nxt = W_VIEW;
        else if (i_btn_run_stop) state_nxt = SW_STOP;
      end
      SW_CLEAR: begin
        state_nxt = i_mode ? W_VIEW : SW_STOP;
      end
      W_VIEW: begin
        if (!i_mode) begin
          state_nxt = SW_STOP;
        end else if (i_btn_clear) begin
          state_nxt = W_EDIT;
          field_nxt = 2'd0;
        end
      end
      W_EDIT: begin
        if (!i_mode) begin
          state_nxt = SW_STOP;
        end else if (i_btn_clear) begin
          state_nxt = W_VIEW;
        end else begin
          if (i_btn_run_stop)           field_nxt = (field == 2'd2) ? 2'd0 : 2'(field + 2'd1);
          else if (i_btn_u && !i_btn_d) inc_nxt = 1'b1;
          else if (i_btn_d && !i_btn_u) dec_nxt = 1'b1;
          // Any pulse reloads the idle count; the final idle count exits edit
          if (any_btn)               cnt_nxt = '0;
          else if (cnt == CNT_LAST)  state_nxt = W_VIEW;
          else                       cnt_nxt = CNT_W'(cnt + CNT_W'(1));
        end
      end
      default: state_nxt = SW_STOP;
    endcase
  end

  assign o_sw_run   = (state == SW_RUN);
  assign o_sw_clear = (state == SW_CLEAR);
  assign o_w_edit   = (state == W_EDIT);
  assign o_w_field  = (state == W_EDIT) ? field : 2'd0;
  assign o_w_inc    = inc_q;
  assign o_w_dec    = dec_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Directed bench for btn_mode_ctrl: per-step expected outputs go through a queue
// and are compared one edge later with immediate assertions.
module tb_btn_mode_ctrl;

  localparam int unsigned TO = 16;

  logic       clk;
  logic       reset;
  logic       i_mode;
  logic       i_btn_run_stop;
  logic       i_btn_clear;
  logic       i_btn_u;
  logic       i_btn_d;
  logic       o_sw_run;
  logic       o_sw_clear;
  logic       o_w_edit;
  logic [1:0] o_w_field;
  logic       o_w_inc;
  logic       o_w_dec;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];

  btn_mode_ctrl #(.EDIT_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_mode         (i_mode),
    .i_btn_run_stop (i_btn_run_stop),
    .i_btn_clear    (i_btn_clear),
    .i_btn_u        (i_btn_u),
    .i_btn_d        (i_btn_d),
    .o_sw_run       (o_sw_run),
    .o_sw_clear     (o_sw_clear),
    .o_w_edit       (o_w_edit),
    .o_w_field      (o_w_field),
    .o_w_inc        (o_w_inc),
    .o_w_dec        (o_w_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output vector: {run, clear, edit, field[1:0], inc, dec}
  function automatic logic [6:0] ev(input logic run, input logic clr, input logic edit,
                                    input logic [1:0] fld, input logic inc, input logic dec);
    return {run, clr, edit, fld, inc, dec};
  endfunction

  function automatic logic [6:0] obs();
    return {o_sw_run, o_sw_clear, o_w_edit, o_w_field, o_w_inc, o_w_dec};
  endfunction

  task automatic check_now(input string tag, input logic [6:0] expv);
    logic [6:0] got;
    got = obs();
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, compare after the edge
  task automatic step(input string tag, input logic mode, input logic rs, input logic clr,
                      input logic u, input logic d, input logic [6:0] expv);
    logic [6:0] want;
    i_mode         = mode;
    i_btn_run_stop = rs;
    i_btn_clear    = clr;
    i_btn_u        = u;
    i_btn_d        = d;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      failures++;
      checks++;
      $error("FAIL %s observed=queue_empty expected=entry", tag);
    end else begin
      want = exp_q.pop_front();
      check_now(tag, want);
    end
  endtask

  initial begin
    reset          = 1'b0;
    i_mode         = 1'b1;
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    i_btn_u        = 1'b0;
    i_btn_d        = 1'b0;

    // Reset held with watch mode selected
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_hold", ev(0,0,0,2'd0,0,0));
    reset = 1'b1;
    step("release_wview",   1, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("wview_idle",      1, 0,0,0,0, ev(0,0,0,2'd0,0,0));

    // Stopwatch run/stop/clear
    step("to_sw_stop",      0, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("sw_start",        0, 1,0,0,0, ev(1,0,0,2'd0,0,0));
    step("sw_running",      0, 0,0,0,0, ev(1,0,0,2'd0,0,0));
    step("sw_clr_running",  0, 0,1,0,0, ev(1,0,0,2'd0,0,0));
    step("sw_clr_not_q",    0, 0,0,0,0, ev(1,0,0,2'd0,0,0));
    step("sw_stop",         0, 1,0,0,0, ev(0,0,0,2'd0,0,0));
    step("sw_clear",        0, 0,1,0,0, ev(0,1,0,2'd0,0,0));
    step("sw_clear_1cyc",   0, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("sw_stays_stop",   0, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("sw_clr_and_rs",   0, 1,1,0,0, ev(0,1,0,2'd0,0,0));
    step("sw_after_both",   0, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("sw_ud_ignored",   0, 0,0,1,1, ev(0,0,0,2'd0,0,0));

    // Watch edit sequence
    step("to_wview",        1, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("wview_rs_ign",    1, 1,0,0,0, ev(0,0,0,2'd0,0,0));
    step("edit_enter",      1, 0,1,0,0, ev(0,0,1,2'd0,0,0));
    step("inc_1",           1, 0,0,1,0, ev(0,0,1,2'd0,1,0));
    step("inc_2",           1, 0,0,1,0, ev(0,0,1,2'd0,1,0));
    step("inc_3",           1, 0,0,1,0, ev(0,0,1,2'd0,1,0));
    step("inc_end",         1, 0,0,0,0, ev(0,0,1,2'd0,0,0));
    step("field_1",         1, 1,0,0,0, ev(0,0,1,2'd1,0,0));
    step("field_2",         1, 1,0,0,0, ev(0,0,1,2'd2,0,0));
    step("field_wrap",      1, 1,0,0,0, ev(0,0,1,2'd0,0,0));
    step("dec_1",           1, 0,0,0,1, ev(0,0,1,2'd0,0,1));
    step("ud_together",     1, 0,0,1,1, ev(0,0,1,2'd0,0,0));
    step("rs_beats_u",      1, 1,0,1,0, ev(0,0,1,2'd1,0,0));
    step("edit_exit",       1, 0,1,0,0, ev(0,0,0,2'd0,0,0));

    // Idle timeout: edit drops exactly TO edges after entry
    step("to_enter",        1, 0,1,0,0, ev(0,0,1,2'd0,0,0));
    for (int k = 1; k <= int'(TO); k++)
      step($sformatf("to_idle_%0d", k), 1, 0,0,0,0, ev(0,0,(k < int'(TO)),2'd0,0,0));

    // Timeout reloaded by a u pulse at cycle 10
    step("to2_enter",       1, 0,1,0,0, ev(0,0,1,2'd0,0,0));
    for (int k = 1; k <= 10 + int'(TO); k++)
      step($sformatf("to2_c%0d", k), 1, 0,0,(k == 10),0,
           ev(0,0,(k < 10 + int'(TO)),2'd0,(k == 10),0));

    // Mode change mid-edit drops the u pulse and the edit
    step("mc_enter",        1, 0,1,0,0, ev(0,0,1,2'd0,0,0));
    step("mc_f1",           1, 1,0,0,0, ev(0,0,1,2'd1,0,0));
    step("mc_f2",           1, 1,0,0,0, ev(0,0,1,2'd2,0,0));
    step("mc_switch_u",     0, 0,0,1,0, ev(0,0,0,2'd0,0,0));
    step("mc_after",        0, 0,0,0,0, ev(0,0,0,2'd0,0,0));

    // Reset mid-run takes effect without a clock edge
    step("rr_start",        0, 1,0,0,0, ev(1,0,0,2'd0,0,0));
    reset = 1'b0;
    #1;
    check_now("reset_mid_run", ev(0,0,0,2'd0,0,0));
    @(posedge clk);
    #1;
    check_now("reset_mid_run_hold", ev(0,0,0,2'd0,0,0));
    reset = 1'b1;

    // Reset mid-edit right after an inc request
    step("re_wview",        1, 0,0,0,0, ev(0,0,0,2'd0,0,0));
    step("re_enter",        1, 0,1,0,0, ev(0,0,1,2'd0,0,0));
    step("re_inc",          1, 0,0,1,0, ev(0,0,1,2'd0,1,0));
    reset = 1'b0;
    #1;
    check_now("reset_mid_edit", ev(0,0,0,2'd0,0,0));
    i_btn_u = 1'b0;
    @(posedge clk);
    #1;
    check_now("reset_mid_edit_hold", ev(0,0,0,2'd0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
